// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding Avalon-MM
// reads to instruction memory and drives the IF/ID pipeline register.
// Optional feature: define IF_MISALIGN_CHECK_EN to add the sticky
// misalign_err output for redirects whose target is not word aligned.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        EnPC,
   input  logic        en,
   input  logic [3:0]  clr,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic [31:0] avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   input  logic        avm_readdatavalid,
   output logic [31:0] Instr,
   output logic [31:0] PC_ID,
   output logic [31:0] PC4_ID,
   output logic        valid_ID,
`ifdef IF_MISALIGN_CHECK_EN
   output logic        misalign_err,
`endif
   output logic        fetch_busy
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

   state_e      state_q, state_d, req_state;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_id_q, pc_id_d;
   logic [31:0] pc4_id_q, pc4_id_d;
   logic        valid_id_q, valid_id_d;
   logic        discard_q, discard_d;

   logic        redir, bad_tgt, halt, flush;
   logic        word_arrive, avail, consume;
   logic [31:0] tgt, word, pc_plus4;
   logic        unused_bits;

`ifdef IF_MISALIGN_CHECK_EN
   logic misalign_q, misalign_d;
   assign misalign_err = misalign_q;
`endif

   assign unused_bits = ^{clr[2:0], br_target[1:0]};

   // Redirect qualification and word availability
   always_comb begin
      tgt      = {br_target[31:2], 2'b00};
      pc_plus4 = pc_q + 32'd4;
      flush    = clr[3];
`ifdef IF_MISALIGN_CHECK_EN
      // Once misaligned, further redirects are ignored and fetching stops.
      redir      = br_taken & ~misalign_q;
      bad_tgt    = redir & (br_target[1:0] != 2'b00);
      misalign_d = misalign_q | bad_tgt;
      halt       = misalign_d;
`else
      redir   = br_taken;
      bad_tgt = 1'b0;
      halt    = 1'b0;
`endif
      req_state   = halt ? StIdle : StReq;
      word_arrive = (state_q == StWait) & avm_readdatavalid & ~discard_q;
      word        = (state_q == StHold) ? hold_q : avm_readdata;
      // A redirect in the same cycle throws the available word away.
      avail       = (word_arrive | (state_q == StHold)) & ~redir;
      consume     = avail & en & EnPC & ~flush;
   end

   // Fetch FSM next state, PC, request address and held word
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      addr_d    = addr_q;
      hold_d    = hold_q;
      discard_d = discard_q;

      if (redir && !bad_tgt) pc_d = tgt;

      case (state_q)
         StIdle: state_d = req_state;
         StReq: begin
            // The request itself stays stable; only its data is marked stale.
            if (redir) discard_d = 1'b1;
            if (!avm_waitrequest) state_d = StWait;
         end
         StWait: begin
            if (avm_readdatavalid) begin
               discard_d = 1'b0;
               if (discard_q || redir) begin
                  state_d = req_state;
               end else if (consume) begin
                  state_d = req_state;
                  pc_d    = pc_plus4;
               end else begin
                  state_d = StHold;
                  hold_d  = avm_readdata;
               end
            end else if (redir) begin
               discard_d = 1'b1;
            end
         end
         StHold: begin
            if (redir) begin
               state_d = req_state;
            end else if (consume) begin
               state_d = req_state;
               pc_d    = pc_plus4;
            end
         end
         default: state_d = StIdle;
      endcase

      // Latch the address only when a new request starts.
      if ((state_d == StReq) && (state_q != StReq)) addr_d = pc_d;
   end

   // IF/ID register next state: flush, then consume, then bubble, else hold
   always_comb begin
      instr_d    = instr_q;
      pc_id_d    = pc_id_q;
      pc4_id_d   = pc4_id_q;
      valid_id_d = valid_id_q;
      if (flush) begin
         instr_d    = NOP_INSTR;
         valid_id_d = 1'b0;
      end else if (consume) begin
         instr_d    = word;
         pc_id_d    = pc_q;
         pc4_id_d   = pc_plus4;
         valid_id_d = 1'b1;
      end else if (en && !avail) begin
         instr_d    = NOP_INSTR;
         valid_id_d = 1'b0;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= StIdle;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         hold_q     <= 32'h0;
         discard_q  <= 1'b0;
         instr_q    <= NOP_INSTR;
         pc_id_q    <= 32'h0;
         pc4_id_q   <= 32'h0;
         valid_id_q <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         hold_q     <= hold_d;
         discard_q  <= discard_d;
         instr_q    <= instr_d;
         pc_id_q    <= pc_id_d;
         pc4_id_q   <= pc4_id_d;
         valid_id_q <= valid_id_d;
`ifdef IF_MISALIGN_CHECK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   // Outputs
   always_comb begin
      avm_read    = (state_q == StReq);
      avm_address = addr_q;
      Instr       = instr_q;
      PC_ID       = pc_id_q;
      PC4_ID      = pc4_id_q;
      valid_ID    = valid_id_q;
      fetch_busy  = ~((state_q == StHold) | word_arrive);
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: zero-wait Avalon memory returning address-derived
// words, directed stimulus with literal expectations, and a program-order
// model of what may legally appear in IF/ID checked every cycle.
module tb_if_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        CLK = 1'b0;
   logic        RST, EnPC, en, br_taken, avm_waitrequest;
   logic [3:0]  clr;
   logic [31:0] br_target;
   logic [31:0] avm_address, avm_readdata, Instr, PC_ID, PC4_ID;
   logic        avm_read, avm_readdatavalid, valid_ID, fetch_busy;
`ifdef IF_MISALIGN_CHECK_EN
   logic        misalign_err;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .CLK               (CLK),
      .RST               (RST),
      .EnPC              (EnPC),
      .en                (en),
      .clr               (clr),
      .br_taken          (br_taken),
      .br_target         (br_target),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_readdata      (avm_readdata),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdatavalid (avm_readdatavalid),
      .Instr             (Instr),
      .PC_ID             (PC_ID),
      .PC4_ID            (PC4_ID),
      .valid_ID          (valid_ID),
`ifdef IF_MISALIGN_CHECK_EN
      .misalign_err      (misalign_err),
`endif
      .fetch_busy        (fetch_busy)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Zero-wait slave: data returns the cycle after acceptance
   initial begin : memory
      logic        acc;
      logic [31:0] a;
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'hDEAD_BEEF;
      forever begin
         @(negedge CLK);
         acc = avm_read && !avm_waitrequest;
         a   = avm_address;
         @(posedge CLK);
         #1;
         avm_readdatavalid = acc;
         avm_readdata      = acc ? mem_word(a) : 32'hDEAD_BEEF;
      end
   end

   // Every-cycle model: IF/ID only ever holds program-order words, bubbles or
   // unchanged contents; bus requests stay stable and never overlap.
   initial begin : compare
      logic        have_prev, p_rst, p_en, p_br, p_read, p_wait, p_valid;
      logic [3:0]  p_clr;
      logic [31:0] p_tgt, p_addr, p_instr, p_pcid, p_pc4, exp_pc;
      int          outst;
      have_prev = 1'b0;
      exp_pc    = RESET_PC;
      outst     = 0;
      forever begin
         @(negedge CLK);
         if (have_prev) begin
            if (p_rst) begin
               exp_pc = RESET_PC;
               outst  = 0;
               chk("m_rst_read", {31'b0, avm_read}, 32'd0);
               chk("m_rst_addr", avm_address, RESET_PC);
               chk("m_rst_instr", Instr, NOP);
               chk("m_rst_pcid", PC_ID, 32'd0);
               chk("m_rst_pc4", PC4_ID, 32'd0);
               chk("m_rst_valid", {31'b0, valid_ID}, 32'd0);
               chk("m_rst_busy", {31'b0, fetch_busy}, 32'd1);
`ifdef IF_MISALIGN_CHECK_EN
               chk("m_rst_misalign", {31'b0, misalign_err}, 32'd0);
`endif
            end else begin
               if (p_clr[3]) begin
                  chk("m_flush_instr", Instr, NOP);
                  chk("m_flush_valid", {31'b0, valid_ID}, 32'd0);
                  chk("m_flush_pcid", PC_ID, p_pcid);
               end else if (!p_en) begin
                  chk("m_hold_instr", Instr, p_instr);
                  chk("m_hold_pcid", PC_ID, p_pcid);
                  chk("m_hold_pc4", PC4_ID, p_pc4);
                  chk("m_hold_valid", {31'b0, valid_ID}, {31'b0, p_valid});
               end else if (valid_ID) begin
                  chk("m_load_pc", PC_ID, exp_pc);
                  chk("m_load_instr", Instr, mem_word(PC_ID));
                  chk("m_load_pc4", PC4_ID, PC_ID + 32'd4);
                  chk("m_load_not_redirect", {31'b0, p_br}, 32'd0);
                  exp_pc = exp_pc + 32'd4;
               end else begin
                  chk("m_bubble_instr", Instr, NOP);
                  chk("m_bubble_pcid", PC_ID, p_pcid);
               end
               if (p_br) exp_pc = {p_tgt[31:2], 2'b00};
               if (p_read && p_wait) begin
                  chk("m_stall_read", {31'b0, avm_read}, 32'd1);
                  chk("m_stall_addr", avm_address, p_addr);
               end
               if (avm_read) chk("m_one_outstanding", 32'(outst), 32'd0);
               if (avm_readdatavalid && outst > 0) outst--;
               if (avm_read && !avm_waitrequest) outst++;
            end
         end
         p_rst   = RST;      p_en   = en;       p_clr  = clr;
         p_br    = br_taken; p_tgt  = br_target;
         p_read  = avm_read; p_wait = avm_waitrequest; p_addr = avm_address;
         p_instr = Instr;    p_pcid = PC_ID;    p_pc4  = PC4_ID; p_valid = valid_ID;
         have_prev = 1'b1;
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Drive point: 2 time units after the rising edge
   task automatic adv();
      @(posedge CLK);
      #2;
   endtask

   // Observation point: the falling edge
   task automatic look();
      #3;
   endtask

   initial begin : stim
      RST = 1'b1; en = 1'b1; EnPC = 1'b1; clr = 4'b0;
      br_taken = 1'b0; br_target = 32'h0; avm_waitrequest = 1'b0;
      adv(); adv();
      RST = 1'b0;
      look();
      chk("reset_read", {31'b0, avm_read}, 32'd0);
      chk("reset_instr", Instr, 32'h0000_0013);
      chk("reset_busy", {31'b0, fetch_busy}, 32'd1);
      adv(); look();                                         // cycle 1
      chk("first_req_read", {31'b0, avm_read}, 32'd1);
      chk("first_req_addr", avm_address, 32'h0);
      adv(); look();                                         // 2
      chk("data_arrive_busy", {31'b0, fetch_busy}, 32'd0);
      adv(); look();                                         // 3
      chk("instr0", Instr, 32'h5A5A_FFFF);
      chk("instr0_valid", {31'b0, valid_ID}, 32'd1);
      chk("instr0_pc4", PC4_ID, 32'h4);
      chk("addr4", avm_address, 32'h4);
      adv(); look();                                         // 4
      chk("bubble_valid", {31'b0, valid_ID}, 32'd0);
      chk("bubble_instr", Instr, 32'h0000_0013);
      adv(); look();                                         // 5
      chk("instr4", Instr, 32'h5A5E_FFFB);
      adv(); look();                                         // 6
      adv(); look();                                         // 7
      chk("instr8", Instr, 32'h5A52_FFF7);
      chk("addrC", avm_address, 32'hC);
      adv(); look();                                         // 8
      adv(); avm_waitrequest = 1'b1;                         // 9
      for (int i = 0; i < 3; i++) begin
         look();
         chk("stall_addr10", avm_address, 32'h10);
         chk("stall_read", {31'b0, avm_read}, 32'd1);
         if (i < 2) adv();
      end
      adv(); avm_waitrequest = 1'b0; look();                 // 12
      chk("stall_end_read", {31'b0, avm_read}, 32'd1);
      adv(); look();                                         // 13
      chk("wait_no_read", {31'b0, avm_read}, 32'd0);
      adv(); look();                                         // 14
      chk("instr10", Instr, 32'h5A4A_FFEF);
      chk("addr14", avm_address, 32'h14);
      adv(); br_taken = 1'b1; br_target = 32'h100; look();   // 15
      adv(); br_taken = 1'b0; look();                        // 16
      chk("redir_addr100", avm_address, 32'h100);
      chk("redir_drop_valid", {31'b0, valid_ID}, 32'd0);
      adv(); look();                                         // 17
      adv(); avm_waitrequest = 1'b1; look();                 // 18
      chk("instr100", Instr, 32'h5B5A_FEFF);
      chk("pcid100", PC_ID, 32'h100);
      adv(); br_taken = 1'b1;                                // 19
`ifdef IF_MISALIGN_CHECK_EN
      br_target = 32'h200;
`else
      br_target = 32'h203;
`endif
      look();
      adv(); br_taken = 1'b0; avm_waitrequest = 1'b0; look(); // 20
      chk("redir_stall_addr", avm_address, 32'h104);
      adv(); look();                                         // 21
      adv(); look();                                         // 22
      chk("discard_addr200", avm_address, 32'h200);
      adv(); look();                                         // 23
      adv(); en = 1'b0; EnPC = 1'b0; look();                 // 24
      chk("instr200", Instr, 32'h585A_FDFF);
      adv(); look();                                         // 25
      adv(); look();                                         // 26
      chk("hold_busy", {31'b0, fetch_busy}, 32'd0);
      chk("hold_no_read", {31'b0, avm_read}, 32'd0);
      adv(); en = 1'b1; EnPC = 1'b1; look();                 // 27
      chk("hold_instr", Instr, 32'h585A_FDFF);
      adv(); look();                                         // 28
      chk("instr204", Instr, 32'h585E_FDFB);
      chk("addr208", avm_address, 32'h208);
      adv(); clr = 4'b1000; look();                          // 29
      adv(); clr = 4'b0000; look();                          // 30
      chk("flush_instr", Instr, 32'h0000_0013);
      chk("flush_valid", {31'b0, valid_ID}, 32'd0);
      adv(); RST = 1'b1; look();                             // 31
      chk("instr208", Instr, 32'h5852_FDF7);
      adv(); RST = 1'b0; look();                             // 32
      chk("midrst_read", {31'b0, avm_read}, 32'd0);
      chk("midrst_valid", {31'b0, valid_ID}, 32'd0);
      adv(); look();                                         // 33
      chk("after_rst_addr", avm_address, 32'h0);
      chk("after_rst_read", {31'b0, avm_read}, 32'd1);
      adv(); look();                                         // 34
      adv(); look();                                         // 35
      chk("after_rst_instr0", Instr, 32'h5A5A_FFFF);
`ifdef IF_MISALIGN_CHECK_EN
      adv(); br_taken = 1'b1; br_target = 32'h102; look();   // 36
      for (int i = 0; i < 4; i++) begin
         adv(); br_taken = 1'b0; look();
         chk("misalign_err", {31'b0, misalign_err}, 32'd1);
         chk("misalign_no_read", {31'b0, avm_read}, 32'd0);
         chk("misalign_valid", {31'b0, valid_ID}, 32'd0);
      end
`endif
      adv();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the Avalon RISC-V pipeline, directly upstream of the hazard detection unit and the decode stage. It owns the program counter and an Avalon-MM read master to instruction memory, and drives the IF/ID pipeline register (instruction, PC, PC+4, valid). It obeys the hazard unit's PC-enable, IF/ID-enable and IF/ID-clear outputs, and it accepts branch/jump redirects from EX.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (`addi x0,x0,0`).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- EnPC  in  1  hazard unit PC enable; 0 = PC frozen.
- en  in  1  hazard unit IF/ID write enable.
- clr  in  4  hazard unit clear vector; bit 3 flushes IF/ID.
- br_taken  in  1  EX redirect strobe, one cycle.
- br_target  in  32  redirect address.
- avm_address  out  32  word-aligned fetch address.
- avm_read  out  1  read request.
- avm_readdata  in  32  fetched word.
- avm_waitrequest  in  1  slave not ready; request must stay stable.
- avm_readdatavalid  in  1  avm_readdata valid.
- Instr  out  32  IF/ID instruction; feeds decode and hazard unit `Instr`.
- PC_ID  out  32  IF/ID PC.
- PC4_ID  out  32  IF/ID PC+4.
- valid_ID  out  1  IF/ID holds a real instruction.
- fetch_busy  out  1  no fetched instruction available this cycle.

## Operation
- The FSM has four states:
  - REQ: avm_read=1 and avm_address=PC. Leave REQ when avm_waitrequest=0.
  - WAIT: waiting for avm_readdatavalid.
  - HOLD: fetched word held locally because it was not consumed.
  - IDLE: one cycle after reset, then REQ.
- Only one read is outstanding at any time.
- Consume condition: (a word arrives in WAIT, or the FSM is in HOLD) and en=1 and EnPC=1 and no flush.
- On consume:
  - IF/ID loads {word, PC, PC+4, valid=1}.
  - PC <= PC+4 (modulo 2^32, wraps to 0).
  - Next state is REQ.
- Word available but en=0 or EnPC=0: the word is held and the state becomes or stays HOLD. IF/ID is unchanged.
- en=1 with no word available: IF/ID loads a bubble (NOP_INSTR, valid=0, PC unchanged).
- en=0: IF/ID holds all fields regardless of fetch progress.
- Flush (clr[3]=1): IF/ID loads a bubble regardless of en. This has priority over consume.
- Redirect (br_taken=1): PC <= br_target and any held word is discarded. Redirect has priority over EnPC. Behaviour by state:
  - In REQ while avm_waitrequest=1: avm_address/avm_read stay stable. A `discard` flag is set, and the return data of that request is dropped.
  - In WAIT: `discard` is set and the returning word is dropped.
  - In HOLD: next state is REQ.
- After a dropped word, the FSM re-enters REQ with the new PC.
- A redirect arriving in the same cycle as the returning word drops that word.
- br_target[1:0] is ignored (forced to 00), except as described under Configuration.
- fetch_busy = 1 in IDLE, REQ and WAIT (unless valid data is arriving and not discarded). It is 0 in HOLD.

## Timing
- Reset values:
  - PC = RESET_PC, state IDLE, avm_read=0, avm_address=RESET_PC.
  - Instr=NOP_INSTR, PC_ID=0, PC4_ID=0, valid_ID=0.
  - fetch_busy=1, discard=0.
- The first avm_read is asserted 2 cycles after RST deasserts (IDLE, then REQ).
- Zero-wait memory (waitrequest=0, readdatavalid one cycle after acceptance): one instruction enters IF/ID every 2 cycles. Instr is visible the cycle after readdatavalid.
- Redirect to first target fetch request: 1 cycle (REQ) when the FSM is in HOLD/WAIT. When stuck in REQ, the target request follows acceptance of the pending request plus its data return.
- RST asserted mid-transaction: everything returns to reset values next cycle. A late avm_readdatavalid from the abandoned read is ignored for 1 cycle after reset, because IDLE ignores readdatavalid.

## Configuration
- IF_MISALIGN_CHECK_EN:
  - Defined: adds output `misalign_err` (1 bit, reset 0). A redirect with br_target[1:0]≠0 sets it sticky until RST. The PC is not updated, and the FSM stops issuing requests; an outstanding read completes and is dropped. IF/ID then receives only bubbles.
  - Undefined: no port; the low bits are forced to 00.

## Test plan
- Reset, then zero-wait memory returning PC-based words, en=EnPC=1 -> addresses 0,4,8 fetched; Instr sequence matches; valid_ID=1 every other cycle.
- avm_waitrequest=1 for 3 cycles on address 0x10 -> avm_address stays 0x10 with avm_read=1 all 3 cycles; one read only.
- Load-use stall: EnPC=en=0 for 2 cycles while a word for 0x8 is held -> IF/ID unchanged, no new read, fetch_busy=0; release -> 0x8 loaded, next request to 0xC.
- br_taken with target 0x100 while the read of 0x14 is in WAIT -> word for 0x14 never reaches IF/ID; next avm_address=0x100.
- clr=4'b1000 with en=1 -> Instr=0x00000013, valid_ID=0.
- IF_MISALIGN_CHECK_EN build, br_target=0x102 -> misalign_err=1, avm_read stays 0 afterwards, valid_ID=0.
